// File: rtl/nes_controller_reader_if.sv
// Request, controller-line and result signals of the NES controller reader.
// The reader takes the slave side; the requester and the controller take the master side.
interface nes_controller_reader_if;
    logic       start;
    logic       ctrl_data;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    modport master (
        output start,
        output ctrl_data,
        input  ctrl_latch,
        input  ctrl_clk,
        input  buttons,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  ctrl_data,
        output ctrl_latch,
        output ctrl_clk,
        output buttons,
        output valid,
        output busy
    );
endinterface

// File: rtl/nes_controller_reader.sv
// NES controller serial reader: drives latch/clock from a divided system clock, shifts in
// eight active-low button bits and presents them as an active-high word with a valid strobe.
module nes_controller_reader #(
    parameter int unsigned HALF_PERIOD = 300
) (
    input  logic                   refclk,
    input  logic                   rst,
    nes_controller_reader_if.slave bus
);

    localparam int unsigned CntW = $clog2(2 * HALF_PERIOD);
    localparam logic [CntW-1:0] LatchLast = CntW'(2 * HALF_PERIOD - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StPulseHi,
        StPulseLo,
        StDone
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [6:0]      r_shift;
    logic [7:0]      r_buttons;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_latch;
    logic            r_clk;
    logic            r_valid;
    logic            r_busy;

    // Released controller line reads as 1, so the synchronizer resets to "not pressed".
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.ctrl_data;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_shift   <= 7'd0;
            r_buttons <= 8'h00;
            r_latch   <= 1'b0;
            r_clk     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + CntW'(1);
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (bus.start) begin
                        r_state <= StLatch;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                StLatch: begin
                    if (r_cnt == LatchLast) begin
                        r_shift <= {r_sync2, r_shift[6:1]};
                        r_idx   <= 3'd1;
                        r_cnt   <= '0;
                        r_latch <= 1'b0;
                        r_clk   <= 1'b1;
                        r_state <= StPulseHi;
                    end
                end
                StPulseHi: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt   <= '0;
                        r_clk   <= 1'b0;
                        r_state <= StPulseLo;
                    end
                end
                StPulseLo: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            // Bits 0..6 sit LSB-first in r_shift; bit 7 is taken straight
                            // from the synchronizer so the word is ready in the valid cycle.
                            r_buttons <= ~{r_sync2, r_shift};
                            r_valid   <= 1'b1;
                            r_state   <= StDone;
                        end else begin
                            r_shift <= {r_sync2, r_shift[6:1]};
                            r_idx   <= r_idx + 3'd1;
                            r_clk   <= 1'b1;
                            r_state <= StPulseHi;
                        end
                    end
                end
                StDone: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_cnt   <= '0;
                    r_latch <= 1'b0;
                    r_clk   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.ctrl_latch = r_latch;
    assign bus.ctrl_clk   = r_clk;
    assign bus.buttons    = r_buttons;
    assign bus.valid      = r_valid;
    assign bus.busy       = r_busy;

endmodule
